// File: rtl/cp0_exc_unit.sv
// CP0 register file and exception/interrupt arbiter at the memory stage.
// Holds Status, Cause, EPC, Count, Compare and BadVAddr, picks at most one
// exception per cycle and drives the pipeline flush and redirect target.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic        valid_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [31:0] bad_addr_i,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Only the writable/live fields are stored; constant bits are rebuilt on read.
    logic [7:0]  status_im_q,  status_im_d;
    logic        status_exl_q, status_exl_d;
    logic        status_ie_q,  status_ie_d;
    logic        cause_bd_q,   cause_bd_d;
    logic        cause_ti_q,   cause_ti_d;
    logic [5:0]  cause_iphw_q, cause_iphw_d;
    logic [1:0]  cause_ipsw_q, cause_ipsw_d;
    logic [4:0]  cause_exc_q,  cause_exc_d;
    logic [31:0] epc_q,        epc_d;
    logic [31:0] count_q,      count_d;
    logic [31:0] compare_q,    compare_d;
    logic [31:0] badvaddr_q,   badvaddr_d;
    logic        tick_q,       tick_d;

    logic [31:0] status_w, cause_w;
    logic        int_pend, exc_take, eret_take, wr_en, bad_load;
    logic [4:0]  exc_code;
    logic [31:0] bad_val;

    // Assemble architectural register views and drive the status outputs.
    always_comb begin
        status_w    = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
        cause_w     = {cause_bd_q, cause_ti_q, 14'd0, cause_iphw_q, cause_ipsw_q,
                       1'b0, cause_exc_q, 2'b00};
        status_o    = status_w;
        cause_o     = cause_w;
        epc_o       = epc_q;
        timer_int_o = cause_ti_q;
    end

    // Priority arbitration: interrupt first, then fetch, decode and memory faults.
    always_comb begin
        int_pend = status_ie_q & ~status_exl_q
                 & (|(status_im_q & {cause_iphw_q, cause_ipsw_q}));
        exc_take = 1'b0;
        exc_code = EXC_INT;
        bad_load = 1'b0;
        bad_val  = bad_addr_i;
        if (valid_i) begin
            exc_take = 1'b1;
            if (int_pend) begin
                exc_code = EXC_INT;
            end else if (adel_if_i) begin
                exc_code = EXC_ADEL;
                bad_load = 1'b1;
                bad_val  = pc_i;
            end else if (ri_i) begin
                exc_code = EXC_RI;
            end else if (ov_i) begin
                exc_code = EXC_OV;
            end else if (syscall_i) begin
                exc_code = EXC_SYS;
            end else if (break_i) begin
                exc_code = EXC_BP;
            end else if (adel_i) begin
                exc_code = EXC_ADEL;
                bad_load = 1'b1;
            end else if (ades_i) begin
                exc_code = EXC_ADES;
                bad_load = 1'b1;
            end else begin
                exc_take = 1'b0;
            end
        end
        eret_take = valid_i & eret_i & ~exc_take;
        wr_en     = we_i & valid_i & ~exc_take;
        // Flush is held low during reset even if stale flags are present.
        flush_o   = resetn & (exc_take | eret_take);
        newpc_o   = exc_take ? EXC_VECTOR : epc_q;
    end

    // MFC0 read path with same-cycle forwarding of the masked MTC0 data.
    always_comb begin
        rdata_o = 32'd0;
        if (we_i && (raddr_i == waddr_i)) begin
            case (waddr_i)
                REG_BADVADDR: rdata_o = badvaddr_q;
                REG_COUNT:    rdata_o = data_i;
                REG_COMPARE:  rdata_o = data_i;
                REG_STATUS:   rdata_o = {9'd0, 1'b1, 6'd0, data_i[15:8], 6'd0, data_i[1:0]};
                REG_CAUSE:    rdata_o = {cause_bd_q, cause_ti_q, 14'd0, cause_iphw_q,
                                         data_i[9:8], 1'b0, cause_exc_q, 2'b00};
                REG_EPC:      rdata_o = data_i;
                default:      rdata_o = 32'd0;
            endcase
        end else begin
            case (raddr_i)
                REG_BADVADDR: rdata_o = badvaddr_q;
                REG_COUNT:    rdata_o = count_q;
                REG_COMPARE:  rdata_o = compare_q;
                REG_STATUS:   rdata_o = status_w;
                REG_CAUSE:    rdata_o = cause_w;
                REG_EPC:      rdata_o = epc_q;
                default:      rdata_o = 32'd0;
            endcase
        end
    end

    // Next-state: timer, interrupt sampling, exception entry, MTC0 and ERET.
    always_comb begin
        status_im_d  = status_im_q;
        status_exl_d = status_exl_q;
        status_ie_d  = status_ie_q;
        cause_bd_d   = cause_bd_q;
        cause_ti_d   = cause_ti_q;
        cause_ipsw_d = cause_ipsw_q;
        cause_exc_d  = cause_exc_q;
        epc_d        = epc_q;
        compare_d    = compare_q;
        badvaddr_d   = badvaddr_q;
        tick_d       = ~tick_q;
        count_d      = count_q + {31'd0, tick_q};
        cause_iphw_d = {int_i[5] | cause_ti_q, int_i[4:0]};
        if (count_q == compare_q) begin
            cause_ti_d = 1'b1;
        end

        if (exc_take) begin
            cause_exc_d  = exc_code;
            status_exl_d = 1'b1;
            // Nested exceptions keep the original return address.
            if (!status_exl_q) begin
                epc_d      = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
                cause_bd_d = in_delay_slot_i;
            end
            if (bad_load) begin
                badvaddr_d = bad_val;
            end
        end else begin
            if (wr_en) begin
                case (waddr_i)
                    REG_COUNT:   count_d = data_i;
                    REG_COMPARE: begin
                        compare_d  = data_i;
                        cause_ti_d = 1'b0;
                    end
                    REG_STATUS:  begin
                        status_im_d  = data_i[15:8];
                        status_exl_d = data_i[1];
                        status_ie_d  = data_i[0];
                    end
                    REG_CAUSE:   cause_ipsw_d = data_i[9:8];
                    REG_EPC:     epc_d = data_i;
                    default:     ;
                endcase
            end
            if (eret_take) begin
                status_exl_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im_q  <= 8'd0;
            status_exl_q <= 1'b0;
            status_ie_q  <= 1'b0;
            cause_bd_q   <= 1'b0;
            cause_ti_q   <= 1'b0;
            cause_iphw_q <= 6'd0;
            cause_ipsw_q <= 2'd0;
            cause_exc_q  <= 5'd0;
            epc_q        <= 32'd0;
            count_q      <= 32'd0;
            compare_q    <= 32'd0;
            badvaddr_q   <= 32'd0;
            tick_q       <= 1'b0;
        end else begin
            status_im_q  <= status_im_d;
            status_exl_q <= status_exl_d;
            status_ie_q  <= status_ie_d;
            cause_bd_q   <= cause_bd_d;
            cause_ti_q   <= cause_ti_d;
            cause_iphw_q <= cause_iphw_d;
            cause_ipsw_q <= cause_ipsw_d;
            cause_exc_q  <= cause_exc_d;
            epc_q        <= epc_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            badvaddr_q   <= badvaddr_d;
            tick_q       <= tick_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed vector table, timer/interrupt
// sequence, and randomized traffic against an abstract register-level model.
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC      = 32'hBFC0_0380;
    localparam logic [7:0]  F_ADELIF = 8'h80;
    localparam logic [7:0]  F_RI     = 8'h40;
    localparam logic [7:0]  F_OV     = 8'h20;
    localparam logic [7:0]  F_SYS    = 8'h10;
    localparam logic [7:0]  F_BRK    = 8'h08;
    localparam logic [7:0]  F_ADEL   = 8'h04;
    localparam logic [7:0]  F_ERET   = 8'h01;
    localparam logic [31:0] CMASK    = 32'h8000_007C;

    logic        clk, resetn, we_i, valid_i, in_delay_slot_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] data_i, pc_i, bad_addr_i;
    logic [5:0]  int_i;
    logic        adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i;
    logic [31:0] rdata_o, newpc_o, status_o, cause_o, epc_o;
    logic        flush_o, timer_int_o;

    cp0_exc_unit #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .resetn(resetn), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .rdata_o(rdata_o), .int_i(int_i), .pc_i(pc_i),
        .in_delay_slot_i(in_delay_slot_i), .valid_i(valid_i), .adel_if_i(adel_if_i),
        .ri_i(ri_i), .ov_i(ov_i), .syscall_i(syscall_i), .break_i(break_i),
        .adel_i(adel_i), .ades_i(ades_i), .eret_i(eret_i), .bad_addr_i(bad_addr_i),
        .flush_o(flush_o), .newpc_o(newpc_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .timer_int_o(timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [4:0]  raddr;
        logic [31:0] data;
        logic        valid;
        logic [7:0]  flags;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        exp_flush;
        logic [31:0] exp_newpc;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_status;
        logic [31:0] exp_cause_m;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vt[12];

    // Reference model state: whole architectural registers.
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_bad;
    logic        m_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [4:0] ra,
                         input logic [31:0] d, input logic v, input logic [7:0] f,
                         input logic [31:0] pc, input logic ds, input logic [31:0] bad,
                         input logic [5:0] irq);
        we_i = we; waddr_i = wa; raddr_i = ra; data_i = d; valid_i = v;
        {adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i} = f;
        pc_i = pc; in_delay_slot_i = ds; bad_addr_i = bad; int_i = irq;
    endtask

    task automatic idle(input logic [4:0] ra);
        drive(1'b0, 5'd0, ra, 32'd0, 1'b0, 8'd0, 32'h8000_0000, 1'b0, 32'd0, 6'd0);
    endtask

    task automatic model_reset();
        m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0;
        m_count = 32'd0; m_compare = 32'd0; m_bad = 32'd0; m_tick = 1'b0;
    endtask

    function automatic logic [4:0] code_of(input int idx);
        case (idx)
            0: return 5'h00;
            1: return 5'h04;
            2: return 5'h0A;
            3: return 5'h0C;
            4: return 5'h08;
            5: return 5'h09;
            6: return 5'h04;
            default: return 5'h05;
        endcase
    endfunction

    // Index into the priority list of the event taken this cycle, -1 if none.
    function automatic int model_take(input logic v, input logic [7:0] f);
        logic [7:0] ev;
        logic pend;
        pend = m_status[0] && !m_status[1] && ((m_status[15:8] & m_cause[15:8]) != 8'd0);
        ev = {pend, f[7:1]};
        if (!v) return -1;
        for (int i = 0; i < 8; i++)
            if (ev[7-i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_reg(input logic [4:0] r);
        case (r)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [4:0] wa, input logic [31:0] d,
                              input logic v, input logic [7:0] f, input logic [31:0] pc,
                              input logic ds, input logic [31:0] bad, input logic [5:0] irq);
        logic [31:0] ns, nc, ne, ncnt, ncmp, nb;
        int t;
        t = model_take(v, f);
        ns = m_status; nc = m_cause; ne = m_epc; ncmp = m_compare; nb = m_bad;
        ncnt = m_tick ? m_count + 32'd1 : m_count;
        nc[15:10] = {irq[5] | m_cause[30], irq[4:0]};
        if (m_count == m_compare) nc[30] = 1'b1;
        if (t >= 0) begin
            nc[6:2] = code_of(t);
            if (!m_status[1]) begin
                ne = ds ? pc - 32'd4 : pc;
                nc[31] = ds;
            end
            ns[1] = 1'b1;
            if (t == 1) nb = pc;
            if (t == 6 || t == 7) nb = bad;
        end else if (v) begin
            if (we) begin
                case (wa)
                    5'd9:  ncnt = d;
                    5'd11: begin ncmp = d; nc[30] = 1'b0; end
                    5'd12: ns = (d & 32'h0000_FF03) | 32'h0040_0000;
                    5'd13: nc[9:8] = d[9:8];
                    5'd14: ne = d;
                    default: ;
                endcase
            end
            if (f[0]) ns[1] = 1'b0;
        end
        m_status = ns; m_cause = nc; m_epc = ne; m_count = ncnt;
        m_compare = ncmp; m_bad = nb; m_tick = ~m_tick;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom % 7)
            0: return 5'd8;
            1: return 5'd9;
            2: return 5'd11;
            3: return 5'd12;
            4: return 5'd13;
            5: return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic rand_cycle();
        logic we, v, ds;
        logic [4:0] wa, ra;
        logic [31:0] d, pc, bad, exp_rd;
        logic [7:0] f;
        logic [5:0] irq;
        int t;
        logic exp_flush;
        v  = ($urandom % 4) != 0;
        we = ($urandom % 3) == 0;
        wa = pick_reg();
        ra = ($urandom % 3 == 0) ? wa : pick_reg();
        d  = $urandom;
        if (wa == 5'd11 && ($urandom % 2 == 0)) d = m_count + 32'($urandom_range(0, 6));
        if (wa == 5'd9 && ($urandom % 3 == 0)) d = 32'hFFFF_FFFE;
        f = 8'd0;
        for (int i = 0; i < 8; i++)
            if ($urandom % 12 == 0) f[i] = 1'b1;
        pc  = {$urandom} & 32'hFFFF_FFFC;
        ds  = 1'($urandom);
        bad = $urandom;
        irq = ($urandom % 8 == 0) ? 6'($urandom) : 6'd0;
        drive(we, wa, ra, d, v, f, pc, ds, bad, irq);
        #1;
        t = model_take(v, f);
        exp_flush = (t >= 0) || (v && f[0]);
        check("rnd_flush", {31'd0, flush_o}, {31'd0, exp_flush});
        if (exp_flush) check("rnd_newpc", newpc_o, (t >= 0) ? VEC : m_epc);
        if (we && ra == wa) begin
            exp_rd = 32'd0;
            case (wa)
                5'd9, 5'd11, 5'd14: exp_rd = d;
                5'd12: exp_rd = (d & 32'h0000_FF03) | 32'h0040_0000;
                default: exp_rd = 32'd0;
            endcase
            if (wa != 5'd8 && wa != 5'd13) check("rnd_rdata_fwd", rdata_o, exp_rd);
        end else begin
            check("rnd_rdata", rdata_o, model_reg(ra));
        end
        check("rnd_status", status_o, m_status);
        check("rnd_cause", cause_o, m_cause);
        check("rnd_epc", epc_o, m_epc);
        check("rnd_timer", {31'd0, timer_int_o}, {31'd0, m_cause[30]});
        tick();
        model_step(we, wa, d, v, f, pc, ds, bad, irq);
    endtask

    initial begin
        vt[0]  = '{1'b1, 5'd11, 5'd0,  32'hFFFF_FFFF, 1'b1, 8'h00, 32'h8000_0000, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000};
        vt[1]  = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, F_SYS, 32'h8000_0100, 1'b0, 32'h0,
                   1'b1, VEC, 1'b0, 32'h0, 32'h0040_0002, 32'h0000_0020, 32'h8000_0100};
        vt[2]  = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, F_ERET, 32'h8000_0104, 1'b0, 32'h0,
                   1'b1, 32'h8000_0100, 1'b0, 32'h0, 32'h0040_0000, 32'h0000_0020, 32'h8000_0100};
        vt[3]  = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, F_RI | F_BRK, 32'h8000_0204, 1'b1, 32'h0,
                   1'b1, VEC, 1'b0, 32'h0, 32'h0040_0002, 32'h8000_0028, 32'h8000_0200};
        vt[4]  = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, F_OV, 32'h8000_0300, 1'b0, 32'h0,
                   1'b1, VEC, 1'b0, 32'h0, 32'h0040_0002, 32'h8000_0030, 32'h8000_0200};
        vt[5]  = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, F_ERET, 32'h8000_0304, 1'b0, 32'h0,
                   1'b1, 32'h8000_0200, 1'b0, 32'h0, 32'h0040_0000, 32'h8000_0030, 32'h8000_0200};
        vt[6]  = '{1'b1, 5'd12, 5'd12, 32'hFFFF_FFFF, 1'b1, 8'h00, 32'h8000_0308, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b1, 32'h0040_FF03, 32'h0040_FF03, 32'h8000_0030, 32'h8000_0200};
        vt[7]  = '{1'b1, 5'd12, 5'd0, 32'h0, 1'b1, F_ADEL, 32'h8000_0400, 1'b0, 32'h1234_5678,
                   1'b1, VEC, 1'b0, 32'h0, 32'h0040_FF03, 32'h8000_0010, 32'h8000_0200};
        vt[8]  = '{1'b0, 5'd0, 5'd8, 32'h0, 1'b0, 8'h00, 32'h8000_0404, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b1, 32'h1234_5678, 32'h0040_FF03, 32'h8000_0010, 32'h8000_0200};
        vt[9]  = '{1'b1, 5'd12, 5'd14, 32'h0, 1'b1, 8'h00, 32'h8000_0408, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b1, 32'h8000_0200, 32'h0040_0000, 32'h8000_0010, 32'h8000_0200};
        vt[10] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, F_ERET | F_SYS, 32'h8000_040C, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0000, 32'h8000_0010, 32'h8000_0200};
        vt[11] = '{1'b1, 5'd14, 5'd14, 32'h8000_1000, 1'b1, 8'h00, 32'h8000_0410, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b1, 32'h8000_1000, 32'h0040_0000, 32'h8000_0010, 32'h8000_1000};

        // Reset held: an exception request must neither flush nor commit.
        resetn = 1'b0;
        drive(1'b0, 5'd0, 5'd12, 32'd0, 1'b1, F_SYS, 32'h8000_0100, 1'b0, 32'd0, 6'd0);
        #2;
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_status_rd", rdata_o, 32'h0040_0000);
        check("rst_timer", {31'd0, timer_int_o}, 32'd0);
        raddr_i = 5'd13;
        #1;
        check("rst_cause_rd", rdata_o, 32'd0);
        tick();
        check("rst_status_hold", status_o, 32'h0040_0000);
        check("rst_epc_hold", epc_o, 32'd0);
        idle(5'd12);
        resetn = 1'b1;
        #1;
        check("rel_status_rd", rdata_o, 32'h0040_0000);
        check("rel_flush", {31'd0, flush_o}, 32'd0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].we, vt[i].waddr, vt[i].raddr, vt[i].data, vt[i].valid, vt[i].flags,
                  vt[i].pc, vt[i].ds, vt[i].bad, 6'd0);
            #1;
            check($sformatf("v%0d_flush", i), {31'd0, flush_o}, {31'd0, vt[i].exp_flush});
            if (vt[i].exp_flush) check($sformatf("v%0d_newpc", i), newpc_o, vt[i].exp_newpc);
            if (vt[i].chk_rd) check($sformatf("v%0d_rdata", i), rdata_o, vt[i].exp_rd);
            tick();
            check($sformatf("v%0d_status", i), status_o, vt[i].exp_status);
            check($sformatf("v%0d_cause", i), cause_o & CMASK, vt[i].exp_cause_m);
            check($sformatf("v%0d_epc", i), epc_o, vt[i].exp_epc);
        end

        // Timer: Count=0, Compare=10, wait for TI, then take the timer interrupt.
        drive(1'b1, 5'd9, 5'd0, 32'd0, 1'b1, 8'h00, 32'h8000_0500, 1'b0, 32'd0, 6'd0);
        tick();
        drive(1'b1, 5'd11, 5'd0, 32'd10, 1'b1, 8'h00, 32'h8000_0504, 1'b0, 32'd0, 6'd0);
        tick();
        check("ti_clear_after_cmp", {31'd0, timer_int_o}, 32'd0);
        idle(5'd0);
        for (int i = 0; i < 40 && !timer_int_o; i++) tick();
        check("ti_set", {31'd0, timer_int_o}, 32'd1);
        check("ti_cause30", {31'd0, cause_o[30]}, 32'd1);
        tick();
        drive(1'b1, 5'd12, 5'd0, 32'h0000_8001, 1'b1, 8'h00, 32'h8000_0600, 1'b0, 32'd0, 6'd0);
        #1;
        check("int_not_yet", {31'd0, flush_o}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 8'h00, 32'h8000_0604, 1'b0, 32'd0, 6'd0);
        #1;
        check("int_flush", {31'd0, flush_o}, 32'd1);
        check("int_newpc", newpc_o, VEC);
        tick();
        check("int_exccode", {27'd0, cause_o[6:2]}, 32'd0);
        check("int_status", status_o, 32'h0040_8003);
        check("int_epc", epc_o, 32'h8000_0604);
        drive(1'b1, 5'd11, 5'd0, 32'hFFFF_FFFF, 1'b1, 8'h00, 32'h8000_0608, 1'b0, 32'd0, 6'd0);
        tick();
        check("ti_cleared_by_cmp", {31'd0, timer_int_o}, 32'd0);

        // Randomized traffic against the model, from a fresh reset.
        idle(5'd0);
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
